// File: rtl/block_dispatcher_if.sv
// Kernel launch and per-core dispatch signals between the host, the block
// dispatcher and the compute cores.
interface block_dispatcher_if #(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4
);
    localparam int CNT_W = $clog2(THREADS_PER_BLOCK) + 1;

    logic                             start;
    logic [7:0]                       thread_count;
    logic                             done;
    logic [NUM_CORES-1:0]             core_start;
    logic [NUM_CORES-1:0]             core_reset;
    logic [NUM_CORES-1:0][7:0]        core_block_id;
    logic [NUM_CORES-1:0][CNT_W-1:0]  core_thread_count;
    logic [NUM_CORES-1:0]             core_done;

    // Host/core side: launches kernels and reports per-core block completion.
    modport master (
        output start, thread_count, core_done,
        input  done, core_start, core_reset, core_block_id, core_thread_count
    );

    // Dispatcher side.
    modport slave (
        input  start, thread_count, core_done,
        output done, core_start, core_reset, core_block_id, core_thread_count
    );
endinterface

// File: rtl/block_dispatcher.sv
// Splits a launched kernel into fixed-size thread blocks, hands blocks to
// idle cores in ascending core order, retires them on core done and raises
// a kernel-level done once every block has completed.
module block_dispatcher #(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4
) (
    input  logic               clk,
    input  logic               reset,
    block_dispatcher_if.slave  bus
);
    localparam int               CNT_W = $clog2(THREADS_PER_BLOCK) + 1;
    localparam logic [8:0]       TPB_9 = 9'(THREADS_PER_BLOCK);
    localparam logic [CNT_W-1:0] TPB_C = CNT_W'(THREADS_PER_BLOCK);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                          state, state_nxt;
    logic [7:0]                      dispatched, dispatched_nxt;
    logic [7:0]                      completed, completed_nxt;
    logic [7:0]                      total_blocks, total_blocks_nxt;
    logic [CNT_W-1:0]                last_count, last_count_nxt;
    logic                            done_q, done_nxt;
    logic [NUM_CORES-1:0]            core_start_q, core_start_nxt;
    logic [NUM_CORES-1:0]            core_reset_q, core_reset_nxt;
    logic [NUM_CORES-1:0][7:0]       block_id_q, block_id_nxt;
    logic [NUM_CORES-1:0][CNT_W-1:0] core_tc_q, core_tc_nxt;
    logic [7:0]                      next_id;
    logic [7:0]                      retired;
    logic                            run_finished;

    // Block count rounded up; 9-bit sum so 255 threads does not wrap.
    function automatic logic [7:0] ceil_blocks(input logic [7:0] threads);
        logic [8:0] sum;
        sum = {1'b0, threads} + TPB_9 - 9'd1;
        return 8'(sum / TPB_9);
    endfunction

    // Threads in the final block; a zero remainder means a full block.
    function automatic logic [CNT_W-1:0] tail_count(input logic [7:0] threads);
        logic [8:0] rem;
        rem = {1'b0, threads} % TPB_9;
        return (rem == 9'd0) ? TPB_C : CNT_W'(rem);
    endfunction

    // Completion uses the registered count, so done lags the last retire by one edge.
    assign run_finished = (state == RUN) && (completed == total_blocks);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (run_finished) state_nxt = DONE;
            DONE:    if (!bus.start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of counters and per-core outputs: dispatch/retire sweep in core order.
    always_comb begin
        dispatched_nxt   = dispatched;
        completed_nxt    = completed;
        total_blocks_nxt = total_blocks;
        last_count_nxt   = last_count;
        done_nxt         = done_q;
        core_start_nxt   = core_start_q;
        core_reset_nxt   = core_reset_q;
        block_id_nxt     = block_id_q;
        core_tc_nxt      = core_tc_q;
        next_id          = dispatched;
        retired          = '0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    total_blocks_nxt = ceil_blocks(bus.thread_count);
                    last_count_nxt   = tail_count(bus.thread_count);
                end
            end
            RUN: begin
                if (run_finished) begin
                    // Nothing is in flight here; park every core in reset.
                    done_nxt       = 1'b1;
                    core_start_nxt = '0;
                    core_reset_nxt = '1;
                end else begin
                    for (int i = 0; i < NUM_CORES; i++) begin
                        if (core_reset_q[i]) begin
                            core_reset_nxt[i] = 1'b0;
                            if (next_id < total_blocks) begin
                                core_start_nxt[i] = 1'b1;
                                block_id_nxt[i]   = next_id;
                                core_tc_nxt[i]    = (next_id == total_blocks - 8'd1) ?
                                                    last_count : TPB_C;
                                next_id           = next_id + 8'd1;
                            end
                        end else if (core_start_q[i] && bus.core_done[i]) begin
                            core_start_nxt[i] = 1'b0;
                            core_reset_nxt[i] = 1'b1;
                            retired           = retired + 8'd1;
                        end
                    end
                    dispatched_nxt = next_id;
                    completed_nxt  = completed + retired;
                end
            end
            DONE: begin
                done_nxt       = 1'b1;
                core_start_nxt = '0;
                core_reset_nxt = '1;
                if (!bus.start) begin
                    done_nxt       = 1'b0;
                    dispatched_nxt = '0;
                    completed_nxt  = '0;
                end
            end
            default: ;
        endcase
    end

    // Counter and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dispatched   <= '0;
            completed    <= '0;
            total_blocks <= '0;
            last_count   <= '0;
            done_q       <= 1'b0;
            core_start_q <= '0;
            core_reset_q <= '1;
            block_id_q   <= '0;
            core_tc_q    <= '0;
        end else begin
            dispatched   <= dispatched_nxt;
            completed    <= completed_nxt;
            total_blocks <= total_blocks_nxt;
            last_count   <= last_count_nxt;
            done_q       <= done_nxt;
            core_start_q <= core_start_nxt;
            core_reset_q <= core_reset_nxt;
            block_id_q   <= block_id_nxt;
            core_tc_q    <= core_tc_nxt;
        end
    end

    assign bus.done              = done_q;
    assign bus.core_start        = core_start_q;
    assign bus.core_reset        = core_reset_q;
    assign bus.core_block_id     = block_id_q;
    assign bus.core_thread_count = core_tc_q;
endmodule

// File: tb/tb_block_dispatcher.sv
// Bench for block_dispatcher: launch table, hand-written corner sequences and
// randomly acknowledged kernels checked against a block-list model.
module tb_block_dispatcher;
    localparam int NC  = 2;
    localparam int TPB = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    block_dispatcher_if #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB)) bus ();

    block_dispatcher #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         tc;
        logic [1:0] exp_start;
        int         exp_cnt0;
        int         exp_cnt1;
        int         exp_id1;
        logic [1:0] exp_rst;
        logic       exp_done;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset            = 1'b0;
        bus.start        = 1'b0;
        bus.thread_count = 8'd0;
        bus.core_done    = '0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic launch(input int tc);
        bus.thread_count = 8'(tc);
        bus.start        = 1'b1;
        tick();
        tick();
    endtask

    // Randomly acknowledged kernel checked against the list of blocks it must produce.
    task automatic run_kernel(input int tc);
        int total;
        int seen [256];
        int nseen;
        int retires;
        int dispatch_bad;
        int inv_bad;
        int edge_n;
        int last_retire_edge;
        int done_edge;
        int id;
        int exp_cnt;
        logic [NC-1:0] prev_start;
        logic [NC-1:0][7:0] prev_id;
        logic [NC-1:0] d;

        total = (tc + TPB - 1) / TPB;
        for (int b = 0; b < 256; b++) seen[b] = 0;
        nseen = 0; retires = 0; dispatch_bad = 0; inv_bad = 0;
        edge_n = 0; last_retire_edge = -1; done_edge = -1;
        prev_start = bus.core_start;
        prev_id    = bus.core_block_id;
        bus.thread_count = 8'(tc);
        bus.start        = 1'b1;
        for (int cyc = 0; cyc < 3000 && done_edge < 0; cyc++) begin
            tick();
            edge_n++;
            bus.core_done = '0;
            if (bus.done) done_edge = edge_n;
            for (int i = 0; i < NC; i++) begin
                if (bus.core_start[i] && bus.core_reset[i]) inv_bad++;
                if (bus.core_start[i] && !prev_start[i]) begin
                    id = int'(bus.core_block_id[i]);
                    if (id >= total || seen[id] != 0) dispatch_bad++;
                    else begin
                        seen[id]++;
                        nseen++;
                    end
                    exp_cnt = tc - id * TPB;
                    if (exp_cnt > TPB) exp_cnt = TPB;
                    if (int'(bus.core_thread_count[i]) != exp_cnt) dispatch_bad++;
                end else if (bus.core_start[i] && prev_start[i] &&
                             bus.core_block_id[i] != prev_id[i]) begin
                    inv_bad++;
                end
            end
            if (done_edge < 0) begin
                for (int i = 0; i < NC; i++) begin
                    d[i] = ($urandom_range(0, 2) == 0);
                    if (d[i] && bus.core_start[i]) begin
                        retires++;
                        last_retire_edge = edge_n + 1;
                    end
                end
                bus.core_done = d;
            end
            prev_start = bus.core_start;
            prev_id    = bus.core_block_id;
        end
        bus.core_done = '0;
        check($sformatf("rnd_tc%0d_finished", tc), int'(done_edge >= 0), 1);
        check($sformatf("rnd_tc%0d_blocks_seen", tc), nseen, total);
        check($sformatf("rnd_tc%0d_retires", tc), retires, total);
        check($sformatf("rnd_tc%0d_done_latency", tc), done_edge, last_retire_edge + 1);
        check($sformatf("rnd_tc%0d_dispatch_errors", tc), dispatch_bad, 0);
        check($sformatf("rnd_tc%0d_invariant_errors", tc), inv_bad, 0);
        check($sformatf("rnd_tc%0d_core_reset", tc), int'(bus.core_reset), 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8,   2'b11, 4, 4, 1, 2'b00, 1'b0};
        vecs[1] = '{10,  2'b11, 4, 4, 1, 2'b00, 1'b0};
        vecs[2] = '{5,   2'b11, 4, 1, 1, 2'b00, 1'b0};
        vecs[3] = '{6,   2'b11, 4, 2, 1, 2'b00, 1'b0};
        vecs[4] = '{4,   2'b01, 4, 0, 0, 2'b00, 1'b0};
        vecs[5] = '{3,   2'b01, 3, 0, 0, 2'b00, 1'b0};
        vecs[6] = '{1,   2'b01, 1, 0, 0, 2'b00, 1'b0};
        vecs[7] = '{0,   2'b00, 0, 0, 0, 2'b11, 1'b1};
        vecs[8] = '{255, 2'b11, 4, 4, 1, 2'b00, 1'b0};

        // Reset values.
        do_reset();
        check("rst_done", int'(bus.done), 0);
        check("rst_core_start", int'(bus.core_start), 0);
        check("rst_core_reset", int'(bus.core_reset), 3);
        check("rst_block_id", int'(bus.core_block_id), 0);
        check("rst_thread_count", int'(bus.core_thread_count), 0);

        // First dispatch for a table of kernel sizes.
        for (int v = 0; v < 9; v++) begin
            do_reset();
            bus.thread_count = 8'(vecs[v].tc);
            bus.start        = 1'b1;
            tick();
            check($sformatf("vec%0d_e0_start", v), int'(bus.core_start), 0);
            check($sformatf("vec%0d_e0_done", v), int'(bus.done), 0);
            tick();
            check($sformatf("vec%0d_start", v), int'(bus.core_start), int'(vecs[v].exp_start));
            check($sformatf("vec%0d_reset", v), int'(bus.core_reset), int'(vecs[v].exp_rst));
            check($sformatf("vec%0d_cnt0", v), int'(bus.core_thread_count[0]), vecs[v].exp_cnt0);
            check($sformatf("vec%0d_cnt1", v), int'(bus.core_thread_count[1]), vecs[v].exp_cnt1);
            check($sformatf("vec%0d_id0", v), int'(bus.core_block_id[0]), 0);
            check($sformatf("vec%0d_id1", v), int'(bus.core_block_id[1]), vecs[v].exp_id1);
            check($sformatf("vec%0d_done", v), int'(bus.done), int'(vecs[v].exp_done));
        end

        // Zero-thread kernel stays parked in reset while done is held.
        do_reset();
        launch(0);
        for (int k = 0; k < 3; k++) tick();
        check("zero_start_idle", int'(bus.core_start), 0);
        check("zero_reset_held", int'(bus.core_reset), 3);
        check("zero_done_held", int'(bus.done), 1);

        // 8 threads: joint retire, done one edge later, DONE hold, relaunch with 5.
        do_reset();
        launch(8);
        bus.core_done = 2'b11;
        tick();
        bus.core_done = 2'b00;
        check("k8_retire_start", int'(bus.core_start), 0);
        check("k8_retire_reset", int'(bus.core_reset), 3);
        check("k8_retire_done", int'(bus.done), 0);
        tick();
        check("k8_done", int'(bus.done), 1);
        check("k8_done_reset", int'(bus.core_reset), 3);
        for (int k = 0; k < 3; k++) tick();
        check("k8_done_hold", int'(bus.done), 1);
        bus.start = 1'b0;
        tick();
        check("k8_done_clear", int'(bus.done), 0);
        launch(5);
        check("k5_start", int'(bus.core_start), 3);
        check("k5_id0", int'(bus.core_block_id[0]), 0);
        check("k5_cnt0", int'(bus.core_thread_count[0]), 4);
        check("k5_id1", int'(bus.core_block_id[1]), 1);
        check("k5_cnt1", int'(bus.core_thread_count[1]), 1);

        // 10 threads: core0 picks up the partial block two edges after the retire.
        do_reset();
        launch(10);
        bus.core_done = 2'b11;
        tick();
        bus.core_done = 2'b00;
        check("k10_retire_reset", int'(bus.core_reset), 3);
        tick();
        check("k10_redispatch_start", int'(bus.core_start), 1);
        check("k10_redispatch_id0", int'(bus.core_block_id[0]), 2);
        check("k10_redispatch_cnt0", int'(bus.core_thread_count[0]), 2);
        check("k10_redispatch_reset", int'(bus.core_reset), 0);
        tick();
        check("k10_not_done", int'(bus.done), 0);
        bus.core_done = 2'b11;
        tick();
        bus.core_done = 2'b00;
        check("k10_last_retire_start", int'(bus.core_start), 0);
        check("k10_last_retire_done", int'(bus.done), 0);
        tick();
        check("k10_done", int'(bus.done), 1);

        // Reset during RUN abandons the kernel; a new launch starts from block 0.
        do_reset();
        launch(8);
        reset = 1'b0;
        tick();
        check("midrst_start", int'(bus.core_start), 0);
        check("midrst_reset", int'(bus.core_reset), 3);
        check("midrst_done", int'(bus.done), 0);
        reset = 1'b1;
        launch(4);
        check("relaunch_start", int'(bus.core_start), 1);
        check("relaunch_id0", int'(bus.core_block_id[0]), 0);
        check("relaunch_cnt0", int'(bus.core_thread_count[0]), 4);

        // Randomly acknowledged kernels, the first one the largest size.
        for (int k = 0; k < 8; k++) begin
            do_reset();
            run_kernel((k == 0) ? 255 : int'($urandom_range(1, 255)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/block_dispatcher.md
# block_dispatcher

Kernel-level dispatcher that sits directly upstream of the compute cores. It splits a launched kernel into blocks of `THREADS_PER_BLOCK` threads and hands each block to an idle core by driving that core's `start`, `block_id` and `thread_count` and holding each unused core in reset. It retires blocks on each core's `done`, re-dispatches freed cores, and raises a kernel-level `done` once every block has completed.

## Interface
Parameters:
- `NUM_CORES`, default 2: number of cores served.
- `THREADS_PER_BLOCK`, default 4: threads per block; must match the cores' parameter.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-low reset.
- `start`  in  1: kernel launch request, level-sensitive.
- `thread_count`  in  8: total threads in the kernel.
- `done`  out  1: kernel complete.
- `core_start`  out  [NUM_CORES]: per-core start.
- `core_reset`  out  [NUM_CORES]: per-core reset, active-high toward the core.
- `core_block_id`  out  [NUM_CORES][8]: block assigned to each core.
- `core_thread_count`  out  [NUM_CORES][$clog2(THREADS_PER_BLOCK)+1]: active threads in the assigned block.
- `core_done`  in  [NUM_CORES]: per-core block complete.

## Operation
- Reset (`reset`=0 at a clock edge) forces:
  - `done`=0, `core_start`=0, `core_reset`=all 1s, `core_block_id`=0, `core_thread_count`=0.
  - Internal counters `dispatched`=0 and `completed`=0; latched total=0; state IDLE.
- States: IDLE, RUN, DONE.
- **IDLE**
  - When `start`=1, latch `total_blocks` = ceil(`thread_count`/`THREADS_PER_BLOCK`). Compute in 9 bits and keep the result in 8 bits.
  - Latch `last_count` = `thread_count` mod `THREADS_PER_BLOCK`, or `THREADS_PER_BLOCK` when that remainder is 0.
  - Go to RUN.
- **RUN**: each edge, for each core i in ascending index order:
  - **Dispatch**: if `core_reset[i]`=1, clear `core_reset[i]`.
    - If blocks remain: set `core_start[i]`=1, `core_block_id[i]`=`dispatched`, and `core_thread_count[i]`=`last_count` when `dispatched`=`total_blocks`-1, else `THREADS_PER_BLOCK`. Then increment `dispatched`.
    - Multiple cores can dispatch in one edge. Lower indices take lower block ids, and the running count is used within the same edge.
    - If no blocks remain, the core stays out of reset with `core_start`=0.
  - **Retire**: if `core_start[i]`=1 and `core_done[i]`=1, set `core_start[i]`=0 and `core_reset[i]`=1. Increment `completed` by the number of cores retiring that edge.
  - A core never dispatches and retires in the same edge, because the dispatch path requires `core_reset`=1 and the retire path requires `core_start`=1.
  - When registered `completed`=`total_blocks`, set `done`=1 and go to DONE.
  - `start` is ignored while in RUN.
  - `core_done` on a core with `core_start`=0 is ignored.
- **DONE**
  - Hold `done`=1 and `core_reset`=all 1s.
  - When `start`=0, clear `done`, zero the counters, and go to IDLE.
- Zero-thread kernel: `total_blocks`=0. The block goes RUN → DONE with no `core_start` ever asserted.
- Reset asserted mid-RUN: every output takes its reset value at that edge. In-flight blocks are abandoned.

## Timing
- Edge E0: IDLE samples `start`=1. Edge E1: first dispatch, so `core_start` is visible after E1.
- Retire → redispatch latency:
  - `core_done` sampled at edge Ek → `core_reset`=1 after Ek.
  - New `core_start`=1 after Ek+1.
  - Per-core turnaround is 2 cycles.
- Kernel completion:
  - `completed` reaches `total_blocks` at edge Ek → `done`=1 after Ek+1.
  - Zero-thread kernel: `done`=1 after E1.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Per-core output relationships:
  - `core_block_id` and `core_thread_count` are stable whenever `core_start`=1.
  - `core_start` and `core_reset` are never both 1.

## Test plan
- `NUM_CORES`=2, `THREADS_PER_BLOCK`=4, `thread_count`=8 → after E1: core0 gets block 0 with count 4, core1 gets block 1 with count 4. Pulse both `core_done` at the same edge → `done`=1 one edge later.
- `thread_count`=10 → blocks 0 and 1 dispatch at E1. Assert `core_done` on both cores in the same edge → core0 receives block 2 with count 2 two edges later; core1 stays idle. `done` asserts only after core0 finishes block 2.
- `thread_count`=0 → `done`=1 after E1. `core_start` is never 1 and `core_reset` stays all 1s.
- `reset`=0 during RUN with both cores busy → at the next edge: `core_start`=00, `core_reset`=11, `done`=0. A following `start` with `thread_count`=4 dispatches block 0 afresh.
- In DONE with `start` held high → `done` stays 1. Drop `start` → `done`=0 next edge. Relaunch with `thread_count`=5 → blocks 0 (count 4) and 1 (count 1).
- `THREADS_PER_BLOCK`=4, `thread_count`=255, with cores acknowledging randomly → 64 blocks with ids 0..63, each dispatched exactly once. Block 63 has count 3; all others have count 4. `done` asserts after the 64th retire.
